conv3x3_stream: RTL
===================

# conv3x3_stream

Parametrised 3x3 RGB convolution engine on the dstream pixel path. It sits between the camera/frame source and the display or VGA sink. The block buffers two image lines in line memories and applies one of four runtime-selectable kernels per frame, with per-mode normalisation shift, saturation and explicit border handling. It exerts full backpressure and emits exactly one output pixel per accepted input pixel.

## Interface
- `IMG_W`, 320, pixels per line (≥4).
- `IMG_H`, 240, lines per frame (≥3).
- `N_CH`, 3, colour channels packed MSB-first (R, G, B).
- `CH_BITS`, 10, bits per channel field in `data`; data width `W = N_CH*CH_BITS`.
- `PIX_BW`, 8, magnitude bits used per channel, taken from the top of each field.
- `COEF_BW`, 8, signed kernel coefficient width.
- `BORDER_PASS`, 0: 0 outputs zero at border centres; 1 passes the centre pixel unchanged.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `x` dstream.in W: input pixels (`data`, `valid`, `ready`).
- `y` dstream.out W: output pixels (`data`, `valid`, `ready`).
- `mode` in 2: kernel select, sampled at frame start.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted input beat (`x.valid & x.ready`). `col` wraps to 0 and `row` increments; at the last pixel both wrap to 0.
- Storage: two line buffers of IMG_W×W, plus a 3x3 window register array shifted on each accepted beat.
- Output pixel for accepted input index i is centred on frame position p = i − (IMG_W+1), modulo IMG_W·IMG_H. The output stream is therefore the input frame spatially delayed by IMG_W+1 beats.
- Border centres use the border value from `BORDER_PASS`. Border centres are row 0, row IMG_H−1, col 0 and col IMG_W−1.
  - All p values falling in the previous frame during the first IMG_W+1 beats are border centres.
  - Stale data after reset and column wrap garbage are never used.
- Mode register `mode_q` loads `mode` on the accepted beat with `row=0, col=0`. It applies to that beat's output and all later outputs until the next frame start.
- Kernels are listed row-major with a normalisation shift:
  - 0: identity (centre 1), shift 0.
  - 1: edge (−1 ×8, centre 8), shift 0.
  - 2: blur (1 2 1 / 2 4 2 / 1 2 1), shift 4.
  - 3: sharpen (0 −1 0 / −1 5 −1 / 0 −1 0), shift 0.
- Arithmetic per channel:
  - Operand is unsigned `PIX_BW` bits, zero-extended to signed.
  - Product width is PIX_BW+COEF_BW+1.
  - Accumulator width is product width + 4.
  - Result is arithmetic-right-shifted by the mode shift.
  - Clamp: <0 → 0; >2^PIX_BW−1 → 2^PIX_BW−1.
  - Output field is the clamped value followed by CH_BITS−PIX_BW zero LSBs.

## Timing
- `x.ready = y.ready | ~y.valid` (combinational). No other internal stall exists.
- On an accepted beat: window and line buffers update, `y.data` ← computed pixel, and `y.valid` ← 1 on the next edge. Latency from acceptance to `y.valid` is one cycle.
- No accepted beat and `y.ready` high: `y.valid` ← 0.
- `y.valid & ~y.ready`: `y.data` and `y.valid` hold stable, and `x.ready` is 0.
- Reset values:
  - `y.valid` = 0, `y.data` = 0, `col` = `row` = 0, `mode_q` = 0.
  - `x.ready` follows its equation, so it is 1 during reset.
  - Line buffers and window are not cleared.
- Input is ignored while `reset` is high.
- Reset mid-frame: the next accepted beat after deassertion is pixel (0,0). Any output pending in `y` is dropped.
- At frame wrap there are no bubbles: the last pixel of frame n and the first pixel of frame n+1 may be accepted on consecutive cycles.

## Test plan
Bench parameters: IMG_W=8, IMG_H=6, BORDER_PASS=0, `y.ready`=1 unless stated.

- **Identity on ramp:** `mode`=0, channel value = (row·8+col). Every output equals the input 9 beats earlier for interior centres and 0 for border centres. Throughput is 1 pixel/cycle and latency is 1 cycle.
- **Edge impulse:** `mode`=1, zero frame with R=G=B=200 at (3,3).
  - Output centred at (3,3) is 0x3FC in every field (8·200 clamped to 255).
  - Its 8 neighbours output 0 (clamped from −200).
  - All other interior centres output 0.
- **Blur flat:** `mode`=2, all channels 100. Interior centres output 0x190 per field ((1600>>4)=100, <<2). Border centres output 0.
- **Backpressure:** two frames with random `y.ready`, 50% duty, including a 3-cycle low burst.
  - Output sequence is identical to the `y.ready`=1 run.
  - `y.data` is stable while stalled, and `x.ready`=0 exactly when `y.valid & ~y.ready`.
- **Mode latch:** `mode` changes 1→2 at input index 20 of frame 0. All of frame 0 uses edge; frame 1 from pixel (0,0) uses blur.
- **Reset mid-frame:** reset is held 1 cycle after 20 accepted beats.
  - `y.valid`=0 the following cycle.
  - The next frame matches the golden model with `mode_q` re-sampled at its pixel (0,0).
  - The first IMG_W+1 outputs after reset are 0.

Source files
------------

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: runtime-selectable 3x3 RGB convolution on a valid/ready
// pixel stream, two line buffers, one output pixel per accepted input pixel.
module conv3x3_stream #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int N_CH        = 3,
  parameter int CH_BITS     = 10,
  parameter int PIX_BW      = 8,
  parameter int COEF_BW     = 8,
  parameter int BORDER_PASS = 0,
  localparam int W          = N_CH * CH_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_x_data,
  input  logic         i_x_valid,
  output logic         o_x_ready,
  output logic [W-1:0] o_y_data,
  output logic         o_y_valid,
  input  logic         i_y_ready,
  input  logic [1:0]   i_mode
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int PW    = PIX_BW + COEF_BW + 1;
  localparam int AW    = PW + 4;
  localparam int MAXV  = (1 << PIX_BW) - 1;
  localparam int LSB   = CH_BITS - PIX_BW;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_mode;
  logic          r_y_valid;
  logic [W-1:0]  r_y_data;
  logic [W-1:0]  r_lb0 [IMG_W];
  logic [W-1:0]  r_lb1 [IMG_W];
  logic [W-1:0]  r_win [3][2];

  logic [W-1:0]  w_col [3];
  logic [W-1:0]  w_win [9];
  logic          w_acc;
  logic          w_sof;
  logic          w_border;
  logic [1:0]    w_mode;
  logic [W-1:0]  w_conv;
  logic [W-1:0]  w_out;

  assign o_x_ready = i_y_ready | ~r_y_valid;
  assign o_y_valid = r_y_valid;
  assign o_y_data  = r_y_data;

  assign w_acc  = i_x_valid & o_x_ready & ~reset;
  assign w_sof  = (r_col == '0) && (r_row == '0);
  assign w_mode = w_sof ? i_mode : r_mode;
  // Centre lags input by one line plus one pixel, so it sits on a
  // border (or in the previous frame) whenever col or row is below 2.
  assign w_border = (r_col < CW'(2)) | (r_row < RW'(2));

  assign w_col[0] = r_lb1[r_col];
  assign w_col[1] = r_lb0[r_col];
  assign w_col[2] = i_x_data;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win[r*3+0] = r_win[r][0];
      w_win[r*3+1] = r_win[r][1];
      w_win[r*3+2] = w_col[r];
    end
  end

  function automatic logic signed [COEF_BW-1:0] coef(
    input logic [1:0] m,
    input int         k
  );
    logic signed [COEF_BW-1:0] c;
    c = '0;
    unique case (m)
      2'd0: c = COEF_BW'((k == 4) ? 1 : 0);
      2'd1: c = COEF_BW'((k == 4) ? 8 : -1);
      2'd2: c = COEF_BW'((k == 4) ? 4 : ((k % 2 == 1) ? 2 : 1));
      2'd3: c = COEF_BW'((k == 4) ? 5 : ((k % 2 == 1) ? -1 : 0));
    endcase
    return c;
  endfunction

  always_comb begin : conv
    logic signed [AW-1:0]   v_acc;
    logic signed [PW-1:0]   v_prod;
    logic signed [PIX_BW:0] v_op;
    logic [PIX_BW-1:0]      v_val;
    v_acc  = '0;
    v_prod = '0;
    v_op   = '0;
    v_val  = '0;
    w_conv = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      v_acc = '0;
      for (int k = 0; k < 9; k++) begin
        v_op   = {1'b0, w_win[k][ch*CH_BITS+LSB +: PIX_BW]};
        v_prod = PW'(v_op) * PW'(coef(w_mode, k));
        v_acc  = v_acc + AW'(v_prod);
      end
      v_acc = v_acc >>> ((w_mode == 2'd2) ? 4 : 0);
      if (v_acc < 0)
        v_val = '0;
      else if (v_acc > AW'(MAXV))
        v_val = '1;
      else
        v_val = v_acc[PIX_BW-1:0];
      w_conv[ch*CH_BITS +: CH_BITS] = CH_BITS'(v_val) << LSB;
    end
  end

  assign w_out = !w_border ? w_conv :
                 (BORDER_PASS != 0) ? w_win[4] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_mode    <= '0;
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
    end else if (w_acc) begin
      r_y_valid <= 1'b1;
      r_y_data  <= w_out;
      if (w_sof)
        r_mode <= i_mode;
      if (r_col == CW'(IMG_W-1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(IMG_H-1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else if (i_y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= i_x_data;
      r_lb1[r_col] <= w_col[1];
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= w_col[r];
      end
    end
  end

endmodule
